wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 116 +++++++++++
 tb/tb_wide_add_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// wide_add_seq: adds two NWORDS x 32-bit operands one word at a time through an
// external registered 32-bit adder, rippling the carry between words via add_cout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a new operand set (in_ready=1)
// ST_ISSUE | word idx presented on add_a/add_b/add_c
// ST_WAIT  | adder result for word idx arrives; stored at the closing edge
// ST_DONE  | wide result valid, held until the out handshake
module wide_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NWORDS-1:0]   a_wide,
  input  logic [32*NWORDS-1:0]   b_wide,
  input  logic                   c_in,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_c,
  input  logic [31:0]            add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NWORDS-1:0]   result,
  output logic                   c_out
);

  localparam int W  = 32 * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IW-1:0]   idx;
  logic            carry_q;
  logic [IW-1:0]   idx_nxt;
  logic [31:0]     a_nxt_word;
  logic [31:0]     b_nxt_word;

  // Operand words for the next ISSUE, so add_a/add_b can be loaded as registers.
  // idx_nxt is only consumed when idx < NWORDS-1, so it never selects past the top word.
  assign idx_nxt    = idx + IW'(1);
  assign a_nxt_word = a_q[32*idx_nxt +: 32];
  assign b_nxt_word = b_q[32*idx_nxt +: 32];

  // Handshake flags decode directly from the state register.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  // The carry register only reaches the adder during ISSUE.
  assign add_c     = (state == ST_ISSUE) && carry_q;

  // Sequencer: latch operands, issue one word per ISSUE/WAIT pair, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      c_out   <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a_wide;
            b_q     <= b_wide;
            carry_q <= c_in;
            idx     <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            add_a   <= a_wide[31:0];
            add_b   <= b_wide[31:0];
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          add_a <= '0;
          add_b <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          result[32*idx +: 32] <= add_sum;
          carry_q              <= add_cout;
          if (idx == LAST_IDX) begin
            c_out <= add_cout;
            state <= ST_DONE;
          end else begin
            idx   <= idx_nxt;
            add_a <= a_nxt_word;
            add_b <= b_nxt_word;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: scoreboard bench for wide_add_seq (NWORDS=4) with a behavioural
// registered 32-bit adder standing in for the downstream datapath.
module tb_wide_add_seq;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_wide;
  logic [W-1:0]  b_wide;
  logic          c_in;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_c;
  logic [31:0]   add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          c_out;

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_wide(a_wide), .b_wide(b_wide), .c_in(c_in),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out)
  );

  always #5 clk = ~clk;

  // Downstream adder: registered a+b+c, one cycle of latency.
  always @(posedge clk) begin
    logic [32:0] s;
    s = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c};
    add_sum  <= s[31:0];
    add_cout <= s[32];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-operand arithmetic, carry-in to word k from the low 32k bits.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int k);
    logic [W:0] mask;
    logic [W:0] s;
    mask = ({{W{1'b0}}, 1'b1} << (32 * k)) - 1;
    s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, c};
    return s[32 * k];
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    int           acc;
  } op_t;

  op_t q[$];
  bit  prev_ov  = 1'b0;
  bit  b2b      = 1'b0;
  int  last_acc = -1;

  // Monitor: samples on the falling edge; pushes on accept, checks and pops on results.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", {{W{1'b0}}, out_valid}, '0);
        end else begin
          if (!prev_ov) check("latency", (W+1)'(cyc - q[0].acc), (W+1)'(2 * NW));
          check("result", {c_out, result}, ref_sum(q[0].a, q[0].b, q[0].c));
          check("in_ready_in_done", (W+1)'(in_ready), '0);
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0) begin
        int d;
        logic [W:0] mask;
        d = cyc - q[0].acc;
        check("in_ready_busy", (W+1)'(in_ready), '0);
        if (d >= 2 * NW) begin
          check("out_valid_late", (W+1)'(out_valid), (W+1)'(1));
        end else begin
          mask = ({{W{1'b0}}, 1'b1} << (32 * (d / 2))) - 1;
          check("partial_result", {1'b0, result}, ref_sum(q[0].a, q[0].b, q[0].c) & mask);
          if (d % 2 == 0)
            check("issue_ports", {add_c, add_b, add_a},
                  {carry_into(q[0].a, q[0].b, q[0].c, d / 2),
                   q[0].b[32*(d/2) +: 32], q[0].a[32*(d/2) +: 32]});
          else
            check("wait_ports_zero", (W+1)'({add_c, add_b, add_a}), '0);
        end
      end else begin
        check("idle_flags", (W+1)'({in_ready, out_valid, add_c, add_b, add_a}),
              (W+1)'({1'b1, 1'b0, 65'd0}));
      end
      if (!b2b) last_acc = -1;
      if (in_valid && in_ready) begin
        q.push_back('{a: a_wide, b: b_wide, c: c_in, acc: cyc + 1});
        if (b2b && last_acc >= 0) check("accept_gap", (W+1)'(cyc + 1 - last_acc), (W+1)'(2 * NW + 2));
        last_acc = cyc + 1;
      end
      prev_ov = out_valid;
    end
  end

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_flag(input string name, input bit want_ready);
    int n;
    n = 0;
    while (((want_ready ? in_ready : out_valid) !== 1'b1) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if ((want_ready ? in_ready : out_valid) !== 1'b1) check(name, '0, (W+1)'(1));
  endtask

  // One operation; hold>0 keeps out_ready low that many cycles in DONE while
  // in_valid is waved with junk operands that must not be taken.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int hold);
    wait_flag("wait_in_ready", 1'b1);
    a_wide = a; b_wide = b; c_in = c; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_flag("wait_out_valid", 1'b0);
    if (hold > 0) begin
      in_valid = 1'b1; a_wide = rand_wide(); b_wide = rand_wide();
      repeat (hold) begin @(posedge clk); #1; end
      check("held_out_valid", (W+1)'(out_valid), (W+1)'(1));
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("out_valid_dropped", (W+1)'(out_valid), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_wide = '0; b_wide = '0; c_in = 1'b0;
    #2;
    check("reset_async", {out_valid, result}, '0);
    check("reset_ports", (W+1)'({in_ready, c_out, add_c, add_b, add_a}), (W+1)'({1'b1, 66'd0}));
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;

    do_op('1, {{(W-1){1'b0}}, 1'b1}, 1'b0, 0);
    do_op({64'd0, 32'h1, 32'hFFFF_FFFF}, {{(W-1){1'b0}}, 1'b1}, 1'b0, 0);
    do_op('0, '0, 1'b1, 0);
    do_op(rand_wide(), rand_wide(), 1'($urandom), 5);

    // Reset during the word-2 WAIT.
    wait_flag("wait_in_ready", 1'b1);
    a_wide = rand_wide(); b_wide = rand_wide(); c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_result", {out_valid, result}, '0);
    check("midop_reset_flags", (W+1)'({in_ready, c_out, add_c, add_b, add_a}), (W+1)'({1'b1, 66'd0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(rand_wide(), rand_wide(), 1'($urandom), 0);

    // Back-to-back with in_valid and out_ready held high.
    wait_flag("wait_in_ready", 1'b1);
    b2b = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_wide = rand_wide(); b_wide = rand_wide(); c_in = 1'($urandom); in_valid = 1'b1;
      wait_flag("b2b_ready", 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_flag("b2b_last_done", 1'b0);
    @(posedge clk); #1;
    b2b = 1'b0;

    for (int i = 0; i < 4; i++) do_op(rand_wide(), rand_wide(), 1'($urandom), i % 2);

    repeat (3) @(posedge clk); #1;
    check("queue_drained", (W+1)'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
